// File: rtl/io_regs_pkg.sv
// Shared register map, control/status bit positions and default window base
// for the memory-mapped timer / IO port block.
package io_regs_pkg;

  localparam logic [15:0] DEFAULT_BASE = 16'hBFF8;

  typedef enum logic [2:0] {
    REG_TLO     = 3'd0,
    REG_THI     = 3'd1,
    REG_CTRL    = 3'd2,
    REG_STATUS  = 3'd3,
    REG_IOPORT  = 3'd4,
    REG_POUT    = 3'd5,
    REG_PIN     = 3'd6,
    REG_SCRATCH = 3'd7
  } reg_off_e;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_EXPIRED = 0;

  // Packed so that bit order matches the CTRL read-back layout.
  typedef struct packed {
    logic irq_en;
    logic auto_rl;
    logic en;
  } ctrl_t;

  function automatic logic [7:0] ctrl_to_byte(input ctrl_t c);
    return {5'b0, c};
  endfunction

endpackage

// File: rtl/io_timer16.sv
// 16-bit reloadable down-counter; expire_pulse marks the cycle in which an
// enabled counter sits at zero and is not being reloaded by software.
module io_timer16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        auto,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic [15:0] reload,
  output logic [15:0] count,
  output logic        expire_pulse
);

  assign expire_pulse = en && !load && (count == 16'd0);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering bugs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (count != 16'd0) begin
        count <= count - 16'd1;
      end else if (auto) begin
        count <= reload;
      end
    end
  end

endmodule

// File: rtl/io_timer_port.sv
// CPU-visible 8-byte register window: reloadable timer with interrupt,
// software-driven irq/nmi lines, an output port and a synchronized input port.
module io_timer_port
  import io_regs_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEFAULT_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        cs,
  input  logic [7:0]  pins_i,
  output logic [7:0]  pins_o,
  output logic        irq,
  output logic        nmi
);

  reg_off_e    offset;
  logic        wr_en;
  logic [15:0] reload_q;
  logic [15:0] count;
  logic        expire_pulse;
  logic        load;
  ctrl_t       ctrl_q;
  logic        expired_q;
  logic [7:0]  ioport_q;
  logic [7:0]  pout_q;
  logic [7:0]  scratch_q;
  logic [7:0]  sync1_q;
  logic [7:0]  sync2_q;

  assign cs     = (address[15:3] == BASE_ADDR[15:3]);
  assign offset = reg_off_e'(address[2:0]);
  assign wr_en  = cs && write;
  assign load   = wr_en && (offset == REG_THI);

  io_timer16 u_timer (
    .clk          (clk),
    .reset        (reset),
    .en           (ctrl_q.en),
    .auto         (ctrl_q.auto_rl),
    .load         (load),
    .load_val     ({data_i, reload_q[7:0]}),
    .reload       (reload_q),
    .count        (count),
    .expire_pulse (expire_pulse)
  );

  // NOTE: every register here is a plain flop with no memory array, so the
  // asynchronous reset clears all of it; there is no state left uninitialised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q  <= 16'd0;
      ctrl_q    <= '0;
      expired_q <= 1'b0;
      ioport_q  <= 8'h00;
      pout_q    <= 8'h00;
      scratch_q <= 8'h00;
    end else begin
      if (wr_en && offset == REG_TLO) reload_q[7:0]  <= data_i;
      if (load)                       reload_q[15:8] <= data_i;

      // Software CTRL writes take priority over the one-shot self-disable.
      if (wr_en && offset == REG_CTRL)
        ctrl_q <= ctrl_t'(data_i[2:0]);
      else if (expire_pulse && !ctrl_q.auto_rl)
        ctrl_q.en <= 1'b0;

      // Set wins over a simultaneous software clear.
      if (expire_pulse)
        expired_q <= 1'b1;
      else if (wr_en && offset == REG_STATUS && data_i[STATUS_EXPIRED])
        expired_q <= 1'b0;

      if (wr_en && offset == REG_IOPORT)  ioport_q  <= data_i;
      if (wr_en && offset == REG_POUT)    pout_q    <= data_i;
      if (wr_en && offset == REG_SCRATCH) scratch_q <= data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: data_o gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    data_o = 8'h00;
    if (cs) begin
      case (offset)
        REG_TLO:     data_o = count[7:0];
        REG_THI:     data_o = count[15:8];
        REG_CTRL:    data_o = ctrl_to_byte(ctrl_q);
        REG_STATUS:  data_o = {7'b0, expired_q};
        REG_IOPORT:  data_o = ioport_q;
        REG_POUT:    data_o = pout_q;
        REG_PIN:     data_o = sync2_q;
        REG_SCRATCH: data_o = scratch_q;
        default:     data_o = 8'h00;
      endcase
    end
  end

  assign irq    = (expired_q & ctrl_q.irq_en) | ioport_q[0];
  assign nmi    = ioport_q[1];
  assign pins_o = pout_q;

endmodule
